// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of a five-stage RISC-V pipeline. It sits directly behind
// the EX/MEM register, performs loads and stores against a variable-latency
// data memory through a req/ack handshake, resolves conditional branches, and
// registers its results into the MEM/WB pipeline register.
//
// Optional feature macro: MEMSTAGE_ALIGN_CHECK_EN
//   defined   : a memory op whose address is not 8-byte aligned is dropped in
//               IDLE (no request, no stall), MEM/WB gets a bubble and
//               misalignOut pulses for one cycle.
//   undefined : every access is issued unmodified and misalignOut stays 0.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   MemRead, MemWrite           memory op controls (both set = store)
//   memToReg, regWrite          write-back controls forwarded to MEM/WB
//   branch, zero                branch resolution inputs
//   WriteData [63:0]            store data
//   add2 [63:0]                 branch target
//   rd [4:0]                    destination register
//   AluResult [63:0]            effective address / ALU result
//   dmem_req/we/addr/wdata      registered memory request channel
//   dmem_ack, dmem_rdata        memory completion strobe and load data
//   stall                       combinational upstream hold
//   pcSrc, branchTarget         combinational branch-taken and target
//   memToRegOut, regWriteOut,
//   rdOut, AluResultOut,
//   ReadDataOut                 MEM/WB register outputs
//   misalignOut                 registered misaligned-access flag
// -----------------------------------------------------------------------------
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        memToReg,
    input  logic        regWrite,
    input  logic        branch,
    input  logic        zero,
    input  logic [63:0] WriteData,
    input  logic [63:0] add2,
    input  logic [4:0]  rd,
    input  logic [63:0] AluResult,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        stall,
    output logic        pcSrc,
    output logic [63:0] branchTarget,
    output logic        memToRegOut,
    output logic        regWriteOut,
    output logic [4:0]  rdOut,
    output logic [63:0] AluResultOut,
    output logic [63:0] ReadDataOut,
    output logic        misalignOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // memory request channel
    logic        req_q,   req_d;
    logic        we_q,    we_d;
    logic [63:0] addr_q,  addr_d;
    logic [63:0] wdata_q, wdata_d;
    // load data captured on ack, presented to MEM/WB in DONE
    logic [63:0] rdata_q, rdata_d;

    // MEM/WB pipeline register
    logic        mtr_q,   mtr_d;
    logic        rw_q,    rw_d;
    logic [4:0]  rd_q,    rd_d;
    logic [63:0] alu_q,   alu_d;
    logic [63:0] rdo_q,   rdo_d;
    logic        mis_q,   mis_d;

    logic        memop;
    logic        misaligned;

    assign memop = MemRead | MemWrite;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
    assign misaligned = (AluResult[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            mtr_q   <= 1'b0;
            rw_q    <= 1'b0;
            rd_q    <= 5'd0;
            alu_q   <= 64'd0;
            rdo_q   <= 64'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mtr_q   <= mtr_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            rdo_q   <= rdo_d;
            mis_q   <= mis_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and combinational outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // Request channel holds its value unless explicitly changed; MEM/WB
        // defaults to a bubble so every waiting cycle injects one.
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mtr_d   = 1'b0;
        rw_d    = 1'b0;
        rd_d    = 5'd0;
        alu_d   = 64'd0;
        rdo_d   = 64'd0;
        mis_d   = 1'b0;
        stall   = 1'b0;
        pcSrc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop && !misaligned) begin
                    stall   = 1'b1;
                    addr_d  = AluResult;
                    wdata_d = WriteData;
                    // MemRead together with MemWrite is treated as a store
                    we_d    = MemWrite;
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if (memop) begin
                    // dropped misaligned access: bubble plus one-cycle flag
                    mis_d = 1'b1;
                end else begin
                    mtr_d = memToReg;
                    rw_d  = regWrite;
                    rd_d  = rd;
                    alu_d = AluResult;
                    pcSrc = branch & zero;
                end
            end

            REQ: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    rdata_d = we_q ? 64'd0 : dmem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                // EX/MEM was held while stalled, so its fields still describe
                // the instruction that just completed.
                mtr_d   = memToReg;
                rw_d    = regWrite;
                rd_d    = rd;
                alu_d   = AluResult;
                rdo_d   = rdata_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // The register clears on a reset edge; keep upstream free-running and
        // suppress branch redirects while reset is held.
        if (reset) begin
            stall = 1'b0;
            pcSrc = 1'b0;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign branchTarget = add2;
    assign memToRegOut  = mtr_q;
    assign regWriteOut  = rw_q;
    assign rdOut        = rd_q;
    assign AluResultOut = alu_q;
    assign ReadDataOut  = rdo_q;
    assign misalignOut  = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, memToReg, regWrite, branch, zero;
    logic [63:0] WriteData, add2, AluResult, dmem_rdata;
    logic [4:0]  rd;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, stall, pcSrc;
    logic [63:0] dmem_addr, dmem_wdata, branchTarget;
    logic        memToRegOut, regWriteOut, misalignOut;
    logic [4:0]  rdOut;
    logic [63:0] AluResultOut, ReadDataOut;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .memToReg(memToReg),
        .regWrite(regWrite), .branch(branch), .zero(zero),
        .WriteData(WriteData), .add2(add2), .rd(rd), .AluResult(AluResult),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
        .memToRegOut(memToRegOut), .regWriteOut(regWriteOut), .rdOut(rdOut),
        .AluResultOut(AluResultOut), .ReadDataOut(ReadDataOut),
        .misalignOut(misalignOut)
    );

    // Expected behaviour of one clock cycle: combinational outputs during the
    // cycle, registered outputs after its closing edge.
    typedef struct packed {
        logic        stall;
        logic        pcsrc;
        logic [63:0] target;
        logic        full_mwb;   // 1: compare all MEM/WB fields, 0: bubble
        logic        mtr;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic        req;
        logic        chk_dm;     // compare we/addr/wdata
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t blank(input logic [63:0] a2);
        exp_t e;
        e = '0;
        e.target = a2;
        return e;
    endfunction

    // Monitor: one expectation consumed per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("stall", {63'd0, stall}, {63'd0, e.stall});
                chk("pcSrc", {63'd0, pcSrc}, {63'd0, e.pcsrc});
                chk("branchTarget", branchTarget, e.target);
                @(posedge clk);
                #1;
                chk("regWriteOut", {63'd0, regWriteOut}, {63'd0, e.rw});
                chk("memToRegOut", {63'd0, memToRegOut}, {63'd0, e.mtr});
                if (e.full_mwb) begin
                    chk("rdOut", {59'd0, rdOut}, {59'd0, e.rd});
                    chk("AluResultOut", AluResultOut, e.alu);
                    chk("ReadDataOut", ReadDataOut, e.rdata);
                end
                chk("dmem_req", {63'd0, dmem_req}, {63'd0, e.req});
                if (e.chk_dm) begin
                    chk("dmem_we", {63'd0, dmem_we}, {63'd0, e.we});
                    chk("dmem_addr", dmem_addr, e.addr);
                    chk("dmem_wdata", dmem_wdata, e.wdata);
                end
                chk("misalignOut", {63'd0, misalignOut}, {63'd0, e.mis});
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic is_misaligned(input logic [63:0] a);
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        return (a[2:0] != 3'b000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t commit(input logic [63:0] a2, input logic mtr, input logic rw,
                                    input logic [4:0] r, input logic [63:0] alu,
                                    input logic [63:0] rdat);
        exp_t e;
        e = blank(a2);
        e.full_mwb = 1'b1;
        e.mtr = mtr; e.rw = rw; e.rd = r; e.alu = alu; e.rdata = rdat;
        return e;
    endfunction

    // One EX/MEM instruction, held for as many cycles as the stage stalls.
    // w = number of REQ cycles without ack before the acking one.
    task automatic op(input logic mr, input logic mw, input logic mtr, input logic rw,
                      input logic br, input logic z, input logic [63:0] wd,
                      input logic [63:0] a2, input logic [4:0] r, input logic [63:0] alu,
                      input int w, input logic [63:0] rdv);
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        MemRead = mr; MemWrite = mw; memToReg = mtr; regWrite = rw;
        branch = br; zero = z; WriteData = wd; add2 = a2; rd = r; AluResult = alu;
        dmem_ack = 1'($urandom_range(0, 1));   // outside REQ, must be ignored
        dmem_rdata = {$urandom, $urandom};
        if (!(mr | mw)) begin
            e = commit(a2, mtr, rw, r, alu, 64'd0);
            e.pcsrc = br & z;
            exp_q.push_back(e);
            $display("txn alu rd=%0d alu=%h br=%0b z=%0b", r, alu, br, z);
        end else if (is_misaligned(alu)) begin
            e = blank(a2);
            e.mis = 1'b1;
            exp_q.push_back(e);
            $display("txn misaligned addr=%h dropped", alu);
        end else begin
            e = blank(a2);
            e.stall = 1'b1; e.req = 1'b1; e.chk_dm = 1'b1;
            e.we = mw; e.addr = alu; e.wdata = wd;
            exp_q.push_back(e);
            for (int k = 0; k <= w; k++) begin
                @(negedge clk);
                dmem_ack = (k == w);
                dmem_rdata = (k == w) ? rdv : {$urandom, $urandom};
                e.req = (k < w);
                e.chk_dm = (k < w);
                exp_q.push_back(e);
            end
            @(negedge clk);
            dmem_ack = 1'($urandom_range(0, 1));
            dmem_rdata = {$urandom, $urandom};
            exp_q.push_back(commit(a2, mtr, rw, r, alu, mw ? 64'd0 : rdv));
            $display("txn %s addr=%h wdata=%h wait=%0d rdata=%h", mw ? "store" : "load",
                     alu, wd, w, mw ? 64'd0 : rdv);
        end
    endtask

    task automatic rst_cycle();
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        dmem_ack = 1'b0;
        e = blank(add2);
        e.full_mwb = 1'b1;
        e.chk_dm = 1'b1;
        exp_q.push_back(e);
        $display("txn reset cycle");
    endtask

    // Load left pending in REQ, reset pulsed, then a late ack.
    task automatic reset_in_req();
        exp_t e;
        @(negedge clk);
        reset = 1'b0;
        MemRead = 1'b1; MemWrite = 1'b0; memToReg = 1'b1; regWrite = 1'b1;
        branch = 1'b0; zero = 1'b0; WriteData = 64'h0; add2 = 64'h10;
        rd = 5'd7; AluResult = 64'h200; dmem_ack = 1'b0;
        e = blank(64'h10);
        e.stall = 1'b1; e.req = 1'b1; e.chk_dm = 1'b1; e.addr = 64'h200;
        exp_q.push_back(e);
        @(negedge clk);
        exp_q.push_back(e);
        rst_cycle();
        @(negedge clk);
        reset = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
        rd = 5'd0; AluResult = 64'd0; add2 = 64'd0;
        dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
        e = commit(64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        e.chk_dm = 1'b1;
        exp_q.push_back(e);
        $display("txn late ack after reset");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; memToReg = 0; regWrite = 0;
        branch = 1; zero = 1;       // pcSrc must stay 0 while in reset
        WriteData = 0; add2 = 64'h44; rd = 0; AluResult = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        rst_cycle();

        op(0, 0, 0, 1, 0, 0, 64'h0, 64'h0, 5'd5, 64'h2A, 0, 64'h0);
        op(1, 0, 1, 1, 0, 0, 64'h0, 64'h0, 5'd3, 64'h100, 0, 64'hDEADBEEF);
        op(0, 1, 0, 0, 0, 0, 64'h55, 64'h0, 5'd0, 64'h80, 4, 64'h0);
        op(0, 0, 0, 0, 1, 1, 64'h0, 64'h400, 5'd0, 64'h0, 0, 64'h0);
        op(0, 0, 0, 0, 1, 0, 64'h0, 64'h400, 5'd0, 64'h0, 0, 64'h0);
        op(1, 1, 1, 1, 1, 1, 64'h77, 64'h500, 5'd9, 64'h88, 1, 64'h1234); // both bits: store
        reset_in_req();
        op(1, 0, 1, 1, 0, 0, 64'h0, 64'h0, 5'd4, 64'h103, 0, 64'hCAFE);

        for (int i = 0; i < 150; i++) begin
            logic        mem;
            logic [63:0] alu;
            mem = 1'($urandom_range(0, 1));
            alu = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) alu[2:0] = 3'b000;
            op(mem & 1'($urandom_range(0, 1)), mem & 1'($urandom_range(0, 1)) | (mem & (alu[3])),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
               alu, int'($urandom_range(0, 4)), {$urandom, $urandom});
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
